// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: segment patterns, digit indices and BCD helper shared by the stopwatch display
package stopwatch_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Digit index of each display position; index 7 is the leftmost digit
    localparam logic [2:0] DIG_HR_T = 3'd7;
    localparam logic [2:0] DIG_HR_U = 3'd6;
    localparam logic [2:0] DIG_MN_T = 3'd5;
    localparam logic [2:0] DIG_MN_U = 3'd4;
    localparam logic [2:0] DIG_SC_T = 3'd3;
    localparam logic [2:0] DIG_SC_U = 3'd2;
    localparam logic [2:0] DIG_CS_T = 3'd1;
    localparam logic [2:0] DIG_CS_U = 3'd0;

    // Digits whose decimal point is lit, giving hh.mm.ss.xx
    localparam logic [7:0] DP_MASK = 8'b0101_0100;

    // Tens or units BCD digit of an 8-bit binary value (meaningful below 100)
    function automatic logic [3:0] bcd_digit(input logic [7:0] v, input logic tens);
        return tens ? 4'(v / 8'd10) : 4'(v % 8'd10);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit with dash/blank overrides to an active-low 7-segment pattern
module seg7_decode
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       dash,
    input  logic       blank,
    output logic [6:0] seg
);

    logic [6:0] digit;

    // Digit lookup; codes above 9 cannot occur for valid values and show blank
    always_comb begin
        case (bcd)
            4'd0:    digit = SEG_0;
            4'd1:    digit = SEG_1;
            4'd2:    digit = SEG_2;
            4'd3:    digit = SEG_3;
            4'd4:    digit = SEG_4;
            4'd5:    digit = SEG_5;
            4'd6:    digit = SEG_6;
            4'd7:    digit = SEG_7;
            4'd8:    digit = SEG_8;
            4'd9:    digit = SEG_9;
            default: digit = SEG_BLANK;
        endcase
    end

    // Blanking beats the dash, which beats the digit
    always_comb begin
        seg = blank ? SEG_BLANK : dash ? SEG_DASH : digit;
    end

endmodule

// File: rtl/stopwatch_display.sv
// stopwatch_display: multiplexed 8-digit hh.mm.ss.xx display with stop blink; STOPWATCH_DISPLAY_LZB_EN blanks a leading hours zero
module stopwatch_display
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int BLINK_HZ = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] hours,
    input  logic [7:0] minutes,
    input  logic [7:0] seconds,
    input  logic [7:0] centisec,
    input  logic       stopped,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
    localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int SW        = $clog2(SCAN_DIV + 1);
    localparam int BW        = $clog2(BLINK_DIV + 1);

    logic [SW-1:0] scan_cnt;
    logic [BW-1:0] blink_cnt;
    logic          phase;
    logic [2:0]    idx;
    logic [7:0]    sh_hr, sh_mn, sh_sc, sh_cs;
    logic [7:0]    dig_an;

    logic          tick, wrap, bwrap, phase_n;
    logic [2:0]    idx_n;
    logic [7:0]    sh_hr_n, sh_mn_n, sh_sc_n, sh_cs_n;
    logic [7:0]    val;
    logic          dash, blank;
    logic [7:0]    dig_an_n;
    logic [6:0]    seg_d;

    // Next-state view: outputs are decoded from the index and snapshot they are about to take,
    // so the first digit of a frame already shows the freshly latched values
    always_comb begin
        tick     = scan_cnt == SW'(SCAN_DIV - 1);
        wrap     = tick && idx == DIG_HR_T;
        idx_n    = tick ? idx + 3'd1 : idx;
        sh_hr_n  = wrap ? hours    : sh_hr;
        sh_mn_n  = wrap ? minutes  : sh_mn;
        sh_sc_n  = wrap ? seconds  : sh_sc;
        sh_cs_n  = wrap ? centisec : sh_cs;
        val      = idx_n[2] ? (idx_n[1] ? sh_hr_n : sh_mn_n) : (idx_n[1] ? sh_sc_n : sh_cs_n);
        dash     = val >= 8'd100;
`ifdef STOPWATCH_DISPLAY_LZB_EN
        blank    = idx_n == DIG_HR_T && sh_hr_n < 8'd10;
`else
        blank    = 1'b0;
`endif
        dig_an_n = tick ? (blank ? 8'hFF : ~(8'b1 << idx_n)) : dig_an;
        bwrap    = blink_cnt == BW'(BLINK_DIV - 1);
        phase_n  = stopped && (phase ^ bwrap);
    end

    seg7_decode u_dec (
        .bcd   (bcd_digit(val, idx_n[0])),
        .dash  (dash),
        .blank (blank),
        .seg   (seg_d)
    );

    // Scan timing, frame-wrap snapshot and per-digit registered segment/dp outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
            sh_hr    <= '0;
            sh_mn    <= '0;
            sh_sc    <= '0;
            sh_cs    <= '0;
            dig_an   <= 8'hFF;
            seg      <= SEG_BLANK;
            dp       <= 1'b1;
        end else begin
            scan_cnt <= tick ? '0 : scan_cnt + 1'b1;
            idx      <= idx_n;
            sh_hr    <= sh_hr_n;
            sh_mn    <= sh_mn_n;
            sh_sc    <= sh_sc_n;
            sh_cs    <= sh_cs_n;
            dig_an   <= dig_an_n;
            if (tick) begin
                seg <= seg_d;
                dp  <= ~DP_MASK[idx_n];
            end
        end
    end

    // Blink timebase runs only while stopped, so a new stop always starts with a lit half-period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            blink_cnt <= (!stopped || bwrap) ? '0 : blink_cnt + 1'b1;
            phase     <= phase_n;
        end
    end

    // Anodes follow the digit every clock and are forced off in the dark blink half
    always_ff @(posedge clk or posedge rst) begin
        if (rst) an <= 8'hFF;
        else     an <= phase_n ? 8'hFF : dig_an_n;
    end

endmodule

// File: tb/tb_stopwatch_display.sv
// tb_stopwatch_display: scoreboard bench, expected display states queued by cycle and checked by a monitor
module tb_stopwatch_display;

    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
    localparam logic [6:0] S5 = 7'h12, S6 = 7'h02, S7 = 7'h78, S8 = 7'h00, SD = 7'h3F, SB = 7'h7F;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] hours = '0, minutes = '0, seconds = '0, centisec = '0;
    logic       stopped = 1'b0;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    stopwatch_display #(.CLK_HZ(800), .SCAN_HZ(100), .BLINK_HZ(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .hours    (hours),
        .minutes  (minutes),
        .seconds  (seconds),
        .centisec (centisec),
        .stopped  (stopped),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        int         tag;
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   base = 0;
    int   tag = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_cmp++;
            if (e.cyc != cyc || an !== e.an || seg !== e.seg || dp !== e.dp) begin
                n_bad++;
                $display("FAIL chk%0d at cycle %0d (due %0d): got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                         e.tag, cyc - base, e.cyc - base, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
    end

    task automatic exp_at(input int n, input logic [7:0] a, input logic [6:0] s, input logic d);
        q.push_back('{cyc: base + n, tag: tag, an: a, seg: s, dp: d});
        tag++;
    endtask

    task automatic wait_to(input int n);
        while (cyc < base + n) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        base = cyc + 1;
        exp_at(0,   8'hFF, SB, 1'b1);
        exp_at(7,   8'hFF, SB, 1'b1);
        exp_at(8,   8'hFD, S0, 1'b1);
        exp_at(16,  8'hFB, S0, 1'b0);
        exp_at(24,  8'hF7, S0, 1'b1);
        exp_at(64,  8'hFE, S8, 1'b1);
        exp_at(67,  8'hFE, S8, 1'b1);
        exp_at(72,  8'hFD, S7, 1'b1);
        exp_at(80,  8'hFB, S6, 1'b0);
        exp_at(88,  8'hF7, S5, 1'b1);
        exp_at(96,  8'hEF, S4, 1'b0);
        exp_at(104, 8'hDF, S3, 1'b1);
        exp_at(112, 8'hBF, S2, 1'b0);
        exp_at(120, 8'h7F, S1, 1'b1);
        exp_at(128, 8'hFE, S0, 1'b1);
        exp_at(144, 8'hFB, S0, 1'b0);
        exp_at(152, 8'hF7, S0, 1'b1);
        exp_at(208, 8'hFB, S1, 1'b0);
        exp_at(240, 8'hBF, S0, 1'b0);
`ifdef STOPWATCH_DISPLAY_LZB_EN
        exp_at(248, 8'hFF, SB, 1'b1);
`else
        exp_at(248, 8'h7F, S0, 1'b1);
`endif
        exp_at(272, 8'hFB, S1, 1'b0);
        exp_at(296, 8'hDF, S0, 1'b1);
        exp_at(304, 8'hBF, SD, 1'b0);
        exp_at(312, 8'h7F, SD, 1'b1);
        exp_at(432, 8'hBF, S5, 1'b0);
`ifdef STOPWATCH_DISPLAY_LZB_EN
        exp_at(440, 8'hFF, SB, 1'b1);
`else
        exp_at(440, 8'h7F, S0, 1'b1);
`endif
        exp_at(649,  8'hFD, S0, 1'b1);
        exp_at(650,  8'hFF, S0, 1'b1);
        exp_at(656,  8'hFF, S1, 1'b0);
        exp_at(849,  8'hFF, S1, 1'b0);
        exp_at(850,  8'hFB, S1, 1'b0);
        exp_at(1050, 8'hFF, S0, 1'b1);
        exp_at(1060, 8'hFF, S0, 1'b0);
        exp_at(1061, 8'hEF, S0, 1'b0);
        exp_at(1300, 8'hFB, S1, 1'b0);
        exp_at(1306, 8'hFF, SB, 1'b1);
        exp_at(1307,      8'hFF, SB, 1'b1);
        exp_at(1307 + 7,  8'hFF, SB, 1'b1);
        exp_at(1307 + 8,  8'hFD, S0, 1'b1);
        exp_at(1307 + 64, 8'hFE, S8, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        wait_to(20);
        {hours, minutes, seconds, centisec} = {8'd12, 8'd34, 8'd56, 8'd78};
        wait_to(121);
        {hours, minutes, seconds, centisec} = '0;
        wait_to(150);
        seconds = 8'd1;
        wait_to(210);
        hours = 8'd150;
        wait_to(320);
        hours = 8'd5;
        wait_to(450);
        stopped = 1'b1;
        wait_to(1060);
        stopped = 1'b0;
        wait_to(1305);
        centisec = 8'd78;
        #2 rst = 1'b1;
        wait_to(1307);
        rst = 1'b0;
        wait_to(1307 + 70);
        if (q.size() != 0) begin
            n_bad += q.size();
            $display("FAIL leftover: %0d expected entries never checked, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
